wb_host_master: RTL and testbench
=================================

// Module: wb_host_master
// PURPOSE
//  Wishbone master driving the master port of wishbone_interconnect. Takes host commands (ping/write/read)
//  over a valid/ready stream, runs single or incrementing-burst wishbone cycles, returns responses on an
//  output valid/ready stream. Reports slave timeouts and interconnect interrupt edges to the host.
// PARAMETERS
//  TIMEOUT_CYCLES  1024  cycles stb may stay high without ack before abort (>=2)
//  CNT_W           24    width of word-count field
// PORTS
//  clk           in   1      system clock, all logic on rising edge
//  rst           in   1      asynchronous, active-low reset
//  in_valid      in   1      host word valid
//  in_ready      out  1      block accepts host word this cycle
//  in_cmd        in   2      0=PING 1=WRITE 2=READ 3=illegal (sampled on command word only)
//  in_addr       in   32     start word address (command word)
//  in_count      in   CNT_W  words to transfer; 0 treated as 1 (command word)
//  in_data       in   32     write data (data words)
//  out_valid     out  1      response valid
//  out_ready     in   1      host accepts response
//  out_status    out  8      01 WRITE_OK, 02 READ_DATA, 03 PING_OK, 04 INTERRUPT, E0 TIMEOUT, E1 BAD_CMD
//  out_addr      out  32     address associated with response
//  out_data      out  32     read data / interrupt vector snapshot
//  out_last      out  1      final response of a command
//  wb_we_o/wb_cyc_o/wb_stb_o  out 1   wishbone controls
//  wb_sel_o      out  4      byte select, 4'hF during stb, else 0
//  wb_adr_o      out  32     wishbone address
//  wb_dat_o      out  32     wishbone write data
//  wb_dat_i      in   32     wishbone read data
//  wb_ack_i      in   1      wishbone acknowledge
//  wb_int_i      in   1      interconnect interrupt summary
// BEHAVIOUR
//  Reset (rst=0): all outputs 0, state IDLE, interrupt pending flag 0, counters 0.
//  States: IDLE, WR_WAIT, WR_BUS, RD_BUS, RD_OUT, RESP, ERR_DRAIN.
//  IDLE: in_ready=1 unless int pending. Pending int has priority: go RESP with status 04,
//   out_data={31'b0,1} style summary (32'h1), out_addr=0, out_last=1; pending clears on out handshake.
//  Int pending set on wb_int_i rising edge (registered compare), in any state; held until reported.
//  PING accepted -> RESP status 03, out_addr=in_addr, out_last=1; out_valid next cycle (latency 1).
//  cmd 3 -> RESP status E1, out_last=1. No bus activity.
//  WRITE: latch addr, remaining=max(count,1); wb_cyc_o=1 from next cycle until command end. WR_WAIT: in_ready=1;
//   on data handshake -> WR_BUS next cycle with stb=1, we=1, adr, dat=latched data. On ack: stb/we/sel
//   drop next cycle, addr+1, remaining-1; remaining 0 -> cyc drops, RESP WRITE_OK, out_addr=start addr,
//   out_data=count done, out_last=1; else WR_WAIT.
//  READ: RD_BUS stb=1 we=0 until ack; latch wb_dat_i on ack; stb drop; RD_OUT out_valid status 02,
//   out_addr=word addr, out_data=latched, out_last=(remaining==1). On out handshake next word or IDLE; cyc low at end.
//  Outputs stable while out_valid=1 and out_ready=0. At most one stb per word; no stb while out_valid pending.
//  Timeout: counter clears at each stb rise, counts while stb=1 & !ack. Reaching TIMEOUT_CYCLES: cyc/stb drop
//   next cycle, RESP status E0, out_addr=failing word address, out_last=1. Ack arriving same cycle as
//   terminal count wins (word completes normally).
//  WRITE abort: remaining data words are consumed and discarded in ERR_DRAIN (in_ready=1, no bus) before TIMEOUT response.
//  Address increments wrap 32'hFFFFFFFF -> 0. Count arithmetic CNT_W bits, no wrap (max 2^CNT_W-1).
//  Reset mid-cycle: cyc/stb drop immediately (async), transaction lost, no response.
// TESTING
//  PING addr 0x0100_0000 -> out_valid 1 cycle later, status 03, addr 0x0100_0000, last=1; no cyc.
//  WRITE addr 0x0000_0010 count 3 data A,B,C, slave ack 1 cycle -> 3 stb pulses at 0x10,0x11,0x12 with A,B,C,
//   cyc high throughout, one WRITE_OK addr 0x10 data 3 last=1.
//  READ addr 0x0100_0000 count 2, out_ready held low 5 cycles -> two READ_DATA, second stb only after first
//   handshake, outputs stable while stalled, last on second only.
//  READ to 0x0200_0000 (no slave, ack never) with TIMEOUT_CYCLES=8 -> stb high exactly 8 cycles, E0 addr 0x0200_0000.
//  wb_int_i 0->1 during a write burst -> burst completes, WRITE_OK, then INTERRUPT response before next command accepted.
//  Reset asserted with stb high -> all wishbone outputs 0 same cycle; after release, PING works normally.

Source files
------------

// File: rtl/wb_host_master_if.sv
// Host command/response streams and the wishbone master port of wb_host_master.
// The master modport is the block's view; slave is the host + interconnect side.
interface wb_host_master_if #(
  parameter int unsigned CNT_W = 24
);
  // Host command stream
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_cmd;
  logic [31:0]      in_addr;
  logic [CNT_W-1:0] in_count;
  logic [31:0]      in_data;

  // Host response stream
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_status;
  logic [31:0]      out_addr;
  logic [31:0]      out_data;
  logic             out_last;

  // Wishbone master port
  logic             wb_we_o;
  logic             wb_cyc_o;
  logic             wb_stb_o;
  logic [3:0]       wb_sel_o;
  logic [31:0]      wb_adr_o;
  logic [31:0]      wb_dat_o;
  logic [31:0]      wb_dat_i;
  logic             wb_ack_i;
  logic             wb_int_i;

  modport master (
    input  in_valid, in_cmd, in_addr, in_count, in_data,
    output in_ready,
    output out_valid, out_status, out_addr, out_data, out_last,
    input  out_ready,
    output wb_we_o, wb_cyc_o, wb_stb_o, wb_sel_o, wb_adr_o, wb_dat_o,
    input  wb_dat_i, wb_ack_i, wb_int_i
  );

  modport slave (
    output in_valid, in_cmd, in_addr, in_count, in_data,
    input  in_ready,
    input  out_valid, out_status, out_addr, out_data, out_last,
    output out_ready,
    input  wb_we_o, wb_cyc_o, wb_stb_o, wb_sel_o, wb_adr_o, wb_dat_o,
    output wb_dat_i, wb_ack_i, wb_int_i
  );
endinterface

// File: rtl/wb_host_master.sv
// Wishbone master turning host PING/WRITE/READ commands into single or incrementing-burst
// bus cycles; reports slave timeouts and interconnect interrupt edges back to the host.
module wb_host_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 24
) (
  input  logic              clk,
  input  logic              rst,
  wb_host_master_if.master  bus,
  output logic [2:0]        dbg_state_o
);
  // Both streams: a word moves on a rising clk edge where valid && ready are both high;
  // a source holds valid and its payload unchanged until that edge.

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WR_WAIT   = 3'd1;
  localparam logic [2:0] S_WR_BUS    = 3'd2;
  localparam logic [2:0] S_RD_BUS    = 3'd3;
  localparam logic [2:0] S_RD_OUT    = 3'd4;
  localparam logic [2:0] S_RESP      = 3'd5;
  localparam logic [2:0] S_ERR_DRAIN = 3'd6;

  localparam logic [1:0] CMD_PING  = 2'd0;
  localparam logic [1:0] CMD_WRITE = 2'd1;
  localparam logic [1:0] CMD_READ  = 2'd2;

  localparam logic [7:0] ST_WRITE_OK  = 8'h01;
  localparam logic [7:0] ST_READ_DATA = 8'h02;
  localparam logic [7:0] ST_PING_OK   = 8'h03;
  localparam logic [7:0] ST_INTERRUPT = 8'h04;
  localparam logic [7:0] ST_TIMEOUT   = 8'hE0;
  localparam logic [7:0] ST_BAD_CMD   = 8'hE1;

  localparam int unsigned      TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [2:0]       state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      start_q, start_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] done_q, done_d;
  logic [31:0]      wdat_q, wdat_d;
  logic             cyc_q, cyc_d;
  logic             stb_q, stb_d;
  logic             we_q, we_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_status_q, out_status_d;
  logic [31:0]      out_addr_q, out_addr_d;
  logic [31:0]      out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             int_prev_q;
  logic             int_pend_q, int_pend_d;

  logic             in_ready_c;
  logic             out_hs;
  logic             int_rise;
  logic [CNT_W-1:0] eff_count;

  assign out_hs    = out_valid_q & bus.out_ready;
  assign int_rise  = bus.wb_int_i & ~int_prev_q;
  assign eff_count = (bus.in_count == '0) ? CNT_ONE : bus.in_count;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    start_d      = start_q;
    rem_d        = rem_q;
    done_d       = done_q;
    wdat_d       = wdat_q;
    cyc_d        = cyc_q;
    stb_d        = stb_q;
    we_d         = we_q;
    tmo_d        = tmo_q;
    out_valid_d  = out_valid_q;
    out_status_d = out_status_q;
    out_addr_d   = out_addr_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    int_pend_d   = int_pend_q;
    in_ready_c   = 1'b0;

    if (stb_q && !bus.wb_ack_i) tmo_d = tmo_q + TMO_W'(1);

    case (state_q)
      S_IDLE: begin
        in_ready_c = ~int_pend_q;
        if (int_pend_q) begin
          out_valid_d  = 1'b1;
          out_status_d = ST_INTERRUPT;
          out_addr_d   = 32'h0;
          out_data_d   = 32'h1;
          out_last_d   = 1'b1;
          state_d      = S_RESP;
        end else if (bus.in_valid) begin
          addr_d  = bus.in_addr;
          start_d = bus.in_addr;
          rem_d   = eff_count;
          done_d  = '0;
          unique case (bus.in_cmd)
            CMD_WRITE: begin
              cyc_d   = 1'b1;
              state_d = S_WR_WAIT;
            end
            CMD_READ: begin
              cyc_d   = 1'b1;
              stb_d   = 1'b1;
              we_d    = 1'b0;
              tmo_d   = '0;
              state_d = S_RD_BUS;
            end
            default: begin
              out_valid_d  = 1'b1;
              out_status_d = (bus.in_cmd == CMD_PING) ? ST_PING_OK : ST_BAD_CMD;
              out_addr_d   = bus.in_addr;
              out_data_d   = 32'h0;
              out_last_d   = 1'b1;
              state_d      = S_RESP;
            end
          endcase
        end
      end

      S_WR_WAIT: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          wdat_d  = bus.in_data;
          stb_d   = 1'b1;
          we_d    = 1'b1;
          tmo_d   = '0;
          state_d = S_WR_BUS;
        end
      end

      S_WR_BUS: begin
        // An ack in the terminal-count cycle still completes the word.
        if (bus.wb_ack_i) begin
          stb_d  = 1'b0;
          we_d   = 1'b0;
          addr_d = addr_q + 32'd1;
          rem_d  = rem_q - CNT_ONE;
          done_d = done_q + CNT_ONE;
          if (rem_q == CNT_ONE) begin
            cyc_d        = 1'b0;
            out_valid_d  = 1'b1;
            out_status_d = ST_WRITE_OK;
            out_addr_d   = start_q;
            out_data_d   = 32'(done_q + CNT_ONE);
            out_last_d   = 1'b1;
            state_d      = S_RESP;
          end else begin
            state_d = S_WR_WAIT;
          end
        end else if (tmo_q == TMO_LAST) begin
          cyc_d        = 1'b0;
          stb_d        = 1'b0;
          we_d         = 1'b0;
          rem_d        = rem_q - CNT_ONE;
          out_status_d = ST_TIMEOUT;
          out_addr_d   = addr_q;
          out_data_d   = 32'h0;
          out_last_d   = 1'b1;
          if (rem_q == CNT_ONE) begin
            out_valid_d = 1'b1;
            state_d     = S_RESP;
          end else begin
            state_d = S_ERR_DRAIN;
          end
        end
      end

      S_ERR_DRAIN: begin
        // Host still owes the aborted burst's data words; swallow them before reporting.
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          rem_d = rem_q - CNT_ONE;
          if (rem_q == CNT_ONE) begin
            out_valid_d = 1'b1;
            state_d     = S_RESP;
          end
        end
      end

      S_RD_BUS: begin
        if (bus.wb_ack_i) begin
          stb_d        = 1'b0;
          out_valid_d  = 1'b1;
          out_status_d = ST_READ_DATA;
          out_addr_d   = addr_q;
          out_data_d   = bus.wb_dat_i;
          out_last_d   = (rem_q == CNT_ONE);
          if (rem_q == CNT_ONE) cyc_d = 1'b0;
          state_d = S_RD_OUT;
        end else if (tmo_q == TMO_LAST) begin
          cyc_d        = 1'b0;
          stb_d        = 1'b0;
          out_valid_d  = 1'b1;
          out_status_d = ST_TIMEOUT;
          out_addr_d   = addr_q;
          out_data_d   = 32'h0;
          out_last_d   = 1'b1;
          state_d      = S_RESP;
        end
      end

      S_RD_OUT: begin
        if (out_hs) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            state_d = S_IDLE;
          end else begin
            addr_d  = addr_q + 32'd1;
            rem_d   = rem_q - CNT_ONE;
            stb_d   = 1'b1;
            tmo_d   = '0;
            state_d = S_RD_BUS;
          end
        end
      end

      S_RESP: begin
        if (out_hs) begin
          out_valid_d = 1'b0;
          if (out_status_q == ST_INTERRUPT) int_pend_d = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // A fresh edge outranks the clear of an earlier one reported this cycle.
    if (int_rise) int_pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      start_q      <= '0;
      rem_q        <= '0;
      done_q       <= '0;
      wdat_q       <= '0;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      we_q         <= 1'b0;
      tmo_q        <= '0;
      out_valid_q  <= 1'b0;
      out_status_q <= '0;
      out_addr_q   <= '0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      int_prev_q   <= 1'b0;
      int_pend_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      start_q      <= start_d;
      rem_q        <= rem_d;
      done_q       <= done_d;
      wdat_q       <= wdat_d;
      cyc_q        <= cyc_d;
      stb_q        <= stb_d;
      we_q         <= we_d;
      tmo_q        <= tmo_d;
      out_valid_q  <= out_valid_d;
      out_status_q <= out_status_d;
      out_addr_q   <= out_addr_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      int_prev_q   <= bus.wb_int_i;
      int_pend_q   <= int_pend_d;
    end
  end

  assign bus.in_ready   = in_ready_c & rst;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_status = out_status_q;
  assign bus.out_addr   = out_addr_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_last   = out_last_q;
  assign bus.wb_cyc_o   = cyc_q;
  assign bus.wb_stb_o   = stb_q;
  assign bus.wb_we_o    = we_q;
  assign bus.wb_sel_o   = {4{stb_q}};
  assign bus.wb_adr_o   = addr_q;
  assign bus.wb_dat_o   = wdat_q;
  assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_wb_host_master.sv
// Directed bench for wb_host_master: host driver tasks, a one-cycle-ack wishbone slave
// that never answers the 0x02xx_xxxx region, and a write log checked against expected entries.
module tb_wb_host_master;
  localparam int CNT_W = 24;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] dbg_state;
  int         n_checks = 0;
  int         n_fail   = 0;

  wb_host_master_if #(.CNT_W(CNT_W)) bus ();

  wb_host_master #(.TIMEOUT_CYCLES(8), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Slave model and bus monitor (values sampled just before each rising edge)
  int          stb_rises = 0, stb_high = 0, cyc_rises = 0, stb_outv = 0, sel_bad = 0;
  logic        stb_prev = 1'b0, cyc_prev = 1'b0;
  logic [63:0] wlog_q[$];
  logic [63:0] exp_q[$];

  assign bus.wb_dat_i = bus.wb_adr_o ^ 32'hA5A5_0000;

  always @(posedge clk) begin
    if (bus.wb_stb_o && !stb_prev) stb_rises++;
    if (bus.wb_stb_o) stb_high++;
    if (bus.wb_cyc_o && !cyc_prev) cyc_rises++;
    if (bus.wb_stb_o && bus.out_valid) stb_outv++;
    if (bus.wb_sel_o !== {4{bus.wb_stb_o}}) sel_bad++;
    if (bus.wb_stb_o && bus.wb_ack_i && bus.wb_we_o) wlog_q.push_back({bus.wb_adr_o, bus.wb_dat_o});
    stb_prev = bus.wb_stb_o;
    cyc_prev = bus.wb_cyc_o;
    bus.wb_ack_i <= rst && bus.wb_stb_o && !bus.wb_ack_i && (bus.wb_adr_o[31:24] != 8'h02);
  end

  // Driver tasks; called at a falling edge and return at a falling edge
  task automatic send_word(input logic [1:0] cmd, input logic [31:0] addr,
                           input logic [CNT_W-1:0] cnt, input logic [31:0] data);
    int waited = 0;
    bus.in_valid = 1'b1;
    bus.in_cmd   = cmd;
    bus.in_addr  = addr;
    bus.in_count = cnt;
    bus.in_data  = data;
    while (!bus.in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_accept: in_ready=%b required 1", bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic recv_resp(output logic [7:0] st, output logic [31:0] ad,
                           output logic [31:0] da, output logic la);
    int waited = 0;
    bus.out_ready = 1'b1;
    while (!bus.out_valid && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL recv_valid: out_valid=%b required 1", bus.out_valid);
    end
    st = bus.out_status;
    ad = bus.out_addr;
    da = bus.out_data;
    la = bus.out_last;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  // Scenarios
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_sel_o} !== 7'h0) begin
      n_fail++;
      $display("FAIL reset_wb: cyc/stb/we/sel=%h required 0", {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_sel_o});
    end
    n_checks++;
    if ({bus.out_valid, bus.out_status, bus.out_last, bus.in_ready} !== 11'h0) begin
      n_fail++;
      $display("FAIL reset_host: valid/status/last/in_ready=%h required 0", {bus.out_valid, bus.out_status, bus.out_last, bus.in_ready});
    end
    n_checks++;
    if (dbg_state !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_state: state=%0d required 0", dbg_state);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_ready: in_ready=%b required 1", bus.in_ready);
    end
  endtask

  task automatic test_ping(input logic [31:0] a);
    logic [7:0] st; logic [31:0] ad, da; logic la;
    int c0 = cyc_rises;
    send_word(2'd0, a, 24'd1, 32'h0);
    n_checks++;
    if (bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL ping_latency: out_valid=%b required 1 one cycle after accept", bus.out_valid);
    end
    recv_resp(st, ad, da, la);
    n_checks++;
    if ({st, ad, la} !== {8'h03, a, 1'b1}) begin
      n_fail++;
      $display("FAIL ping_resp: status=%h addr=%h last=%b required 03 %h 1", st, ad, la, a);
    end
    n_checks++;
    if (cyc_rises - c0 !== 0) begin
      n_fail++;
      $display("FAIL ping_no_cyc: cyc pulses=%0d required 0", cyc_rises - c0);
    end
  endtask

  task automatic test_write(input logic [31:0] a, input logic [31:0] d0,
                            input logic [31:0] d1, input logic [31:0] d2, input int n);
    logic [7:0] st; logic [31:0] ad, da; logic la;
    logic [31:0] wd[3];
    int s0 = stb_rises, c0 = cyc_rises, w0 = wlog_q.size();
    wd[0] = d0; wd[1] = d1; wd[2] = d2;
    exp_q = {};
    for (int i = 0; i < n; i++) exp_q.push_back({a + 32'(i), wd[i]});
    send_word(2'd1, a, 24'(n), 32'h0);
    for (int i = 0; i < n; i++) send_word(2'd3, 32'hDEAD_BEEF, 24'd0, wd[i]);
    recv_resp(st, ad, da, la);
    n_checks++;
    if ({st, ad, da, la} !== {8'h01, a, 32'(n), 1'b1}) begin
      n_fail++;
      $display("FAIL write_resp: status=%h addr=%h data=%h last=%b required 01 %h %h 1", st, ad, da, la, a, 32'(n));
    end
    n_checks++;
    if (stb_rises - s0 !== n || cyc_rises - c0 !== 1) begin
      n_fail++;
      $display("FAIL write_pulses: stb=%0d cyc=%0d required %0d 1", stb_rises - s0, cyc_rises - c0, n);
    end
    n_checks++;
    if (wlog_q.size() - w0 !== n) begin
      n_fail++;
      $display("FAIL write_count: logged=%0d required %0d", wlog_q.size() - w0, n);
    end else begin
      for (int i = 0; i < n; i++) begin
        n_checks++;
        if (wlog_q[w0 + i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL write_word%0d: adr/dat=%h required %h", i, wlog_q[w0 + i], exp_q[i]);
        end
      end
    end
    n_checks++;
    if (sel_bad !== 0) begin
      n_fail++;
      $display("FAIL sel_follows_stb: bad cycles=%0d required 0", sel_bad);
    end
  endtask

  task automatic test_read_stall();
    logic [7:0] st; logic [31:0] ad, da; logic la;
    logic [72:0] snap;
    int s0 = stb_rises, o0 = stb_outv, waited = 0;
    bus.out_ready = 1'b0;
    send_word(2'd2, 32'h0100_0000, 24'd2, 32'h0);
    while (!bus.out_valid && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    snap = {bus.out_status, bus.out_addr, bus.out_data, bus.out_last};
    n_checks++;
    if (snap !== {8'h02, 32'h0100_0000, 32'hA4A5_0000, 1'b0}) begin
      n_fail++;
      $display("FAIL read_first: resp=%h required %h", snap, {8'h02, 32'h0100_0000, 32'hA4A5_0000, 1'b0});
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.out_valid, bus.out_status, bus.out_addr, bus.out_data, bus.out_last} !== {1'b1, snap}) begin
        n_fail++;
        $display("FAIL read_stall_stable: cycle %0d resp=%h required %h", i,
                 {bus.out_valid, bus.out_status, bus.out_addr, bus.out_data, bus.out_last}, {1'b1, snap});
      end
    end
    n_checks++;
    if (stb_rises - s0 !== 1) begin
      n_fail++;
      $display("FAIL read_stall_stb: stb pulses=%0d required 1", stb_rises - s0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    recv_resp(st, ad, da, la);
    n_checks++;
    if ({st, ad, da, la} !== {8'h02, 32'h0100_0001, 32'hA4A5_0001, 1'b1}) begin
      n_fail++;
      $display("FAIL read_second: status=%h addr=%h data=%h last=%b required 02 01000001 a4a50001 1", st, ad, da, la);
    end
    n_checks++;
    if (stb_rises - s0 !== 2 || stb_outv - o0 !== 0 || bus.wb_cyc_o !== 1'b0) begin
      n_fail++;
      $display("FAIL read_bus: stb=%0d stb_with_valid=%0d cyc=%b required 2 0 0", stb_rises - s0, stb_outv - o0, bus.wb_cyc_o);
    end
  endtask

  task automatic test_bad_cmd();
    logic [7:0] st; logic [31:0] ad, da; logic la;
    int c0 = cyc_rises;
    send_word(2'd3, 32'h1234_5678, 24'd1, 32'h0);
    recv_resp(st, ad, da, la);
    n_checks++;
    if ({st, la} !== {8'hE1, 1'b1} || cyc_rises - c0 !== 0) begin
      n_fail++;
      $display("FAIL bad_cmd: status=%h last=%b cyc pulses=%0d required e1 1 0", st, la, cyc_rises - c0);
    end
  endtask

  task automatic test_read_timeout();
    logic [7:0] st; logic [31:0] ad, da; logic la;
    int h0 = stb_high, s0 = stb_rises;
    send_word(2'd2, 32'h0200_0000, 24'd0, 32'h0);
    recv_resp(st, ad, da, la);
    n_checks++;
    if ({st, ad, la} !== {8'hE0, 32'h0200_0000, 1'b1}) begin
      n_fail++;
      $display("FAIL rd_timeout_resp: status=%h addr=%h last=%b required e0 02000000 1", st, ad, la);
    end
    n_checks++;
    if (stb_high - h0 !== 8 || stb_rises - s0 !== 1 || bus.wb_cyc_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_timeout_stb: high=%0d pulses=%0d cyc=%b required 8 1 0", stb_high - h0, stb_rises - s0, bus.wb_cyc_o);
    end
  endtask

  task automatic test_write_timeout();
    logic [7:0] st; logic [31:0] ad, da; logic la;
    int h0 = stb_high, s0 = stb_rises, w0 = wlog_q.size();
    send_word(2'd1, 32'h0200_0000, 24'd3, 32'h0);
    for (int i = 0; i < 3; i++) send_word(2'd0, 32'h0, 24'd0, 32'h5000 + 32'(i));
    recv_resp(st, ad, da, la);
    n_checks++;
    if ({st, ad, la} !== {8'hE0, 32'h0200_0000, 1'b1}) begin
      n_fail++;
      $display("FAIL wr_timeout_resp: status=%h addr=%h last=%b required e0 02000000 1", st, ad, la);
    end
    n_checks++;
    if (stb_high - h0 !== 8 || stb_rises - s0 !== 1 || wlog_q.size() - w0 !== 0) begin
      n_fail++;
      $display("FAIL wr_timeout_drain: high=%0d pulses=%0d acked=%0d required 8 1 0",
               stb_high - h0, stb_rises - s0, wlog_q.size() - w0);
    end
  endtask

  task automatic test_interrupt();
    logic [7:0] st; logic [31:0] ad, da; logic la;
    send_word(2'd1, 32'h0000_0020, 24'd2, 32'h0);
    send_word(2'd0, 32'h0, 24'd0, 32'h1111_0000);
    bus.wb_int_i = 1'b1;
    send_word(2'd0, 32'h0, 24'd0, 32'h2222_0000);
    recv_resp(st, ad, da, la);
    n_checks++;
    if ({st, ad, da, la} !== {8'h01, 32'h20, 32'h2, 1'b1}) begin
      n_fail++;
      $display("FAIL int_burst_done: status=%h addr=%h data=%h last=%b required 01 20 2 1", st, ad, da, la);
    end
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL int_blocks_cmd: in_ready=%b required 0", bus.in_ready);
    end
    recv_resp(st, ad, da, la);
    n_checks++;
    if ({st, ad, da, la} !== {8'h04, 32'h0, 32'h1, 1'b1}) begin
      n_fail++;
      $display("FAIL int_resp: status=%h addr=%h data=%h last=%b required 04 0 1 1", st, ad, da, la);
    end
    // Level still high: no second report expected.
    test_ping(32'h0000_0ABC);
    bus.wb_int_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    send_word(2'd2, 32'h0200_0000, 24'd1, 32'h0);
    @(negedge clk);
    n_checks++;
    if (bus.wb_stb_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_pre: stb=%b required 1", bus.wb_stb_o);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_sel_o} !== 7'h0) begin
      n_fail++;
      $display("FAIL rst_mid_async: cyc/stb/we/sel=%h required 0", {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_sel_o});
    end
    @(negedge clk);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0 || bus.wb_cyc_o !== 1'b0) bad++;
    end
    bus.out_ready = 1'b0;
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL rst_mid_lost: cycles with response or cyc=%0d required 0", bad);
    end
    test_ping(32'h0300_0004);
  endtask

  // Sequence and report
  initial begin
    bus.in_valid  = 1'b0;
    bus.in_cmd    = 2'd0;
    bus.in_addr   = 32'h0;
    bus.in_count  = '0;
    bus.in_data   = 32'h0;
    bus.out_ready = 1'b0;
    bus.wb_int_i  = 1'b0;
    @(negedge clk);
    test_reset();
    test_ping(32'h0100_0000);
    test_write(32'h0000_0010, 32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 3);
    test_read_stall();
    test_bad_cmd();
    test_read_timeout();
    test_write_timeout();
    test_write(32'hFFFF_FFFF, 32'h1111_1111, 32'h2222_2222, 32'h0, 2);
    test_interrupt();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
